// File: rtl/game_pkg.sv
// Shared game-flow types: sequencer state encoding used by the flow
// controller and by the overlay/score blocks.
package game_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LVL_INTRO = 4'd1,
    PLAY      = 4'd2,
    PAUSE     = 4'd3,
    HIT       = 4'd4,
    RESPAWN   = 4'd5,
    LVL_CLEAR = 4'd6,
    WIN       = 4'd7,
    LOSE      = 4'd8
  } game_st_t;

  // States whose exit is timed by the frame-tick delay counter
  function automatic logic isDelaySt(input game_st_t st);
    return (st == LVL_INTRO) || (st == HIT) || (st == RESPAWN);
  endfunction

endpackage

// File: rtl/tick_delay_counter.sv
// Frame-tick delay counter: counts tick strobes since the last clear and
// flags the tick that reaches the terminal count.
module tick_delay_counter #(
  parameter int DELAY_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               tick,
  input  logic [DELAY_W-1:0] term,
  output logic               done
);

  logic [DELAY_W-1:0] cnt;

  // done on the tick that completes the delay, so the caller can move on that same edge
  assign done = tick && (cnt == term);

  // Count ticks; clear wins so an entry cycle always starts from zero
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (tick)    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: pre-game, multi-level play, life loss, respawn,
// pause and win/lose. Delays are counted in frame ticks internally.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LIVES   = 3,
  parameter int LIVES_W     = 4,
  parameter int NUM_LEVELS  = 4,
  parameter int LEVEL_W     = 3,
  parameter int DELAY_W     = 8,
  parameter int HIT_TICKS   = 60,
  parameter int INTRO_TICKS = 90
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               startBtn,
  input  logic               pauseBtn,
  input  logic               charHit,
  input  logic               levelClear,
  output logic               bubbleStart,
  output logic               charStart,
  output logic               freeze,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic [3:0]         gameState
);

  localparam logic [DELAY_W-1:0] HIT_TERM   = DELAY_W'(HIT_TICKS - 1);
  localparam logic [DELAY_W-1:0] INTRO_TERM = DELAY_W'(INTRO_TICKS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

  game_st_t           state, nextState;
  logic               dlyDone, dlyClr;
  logic [DELAY_W-1:0] dlyTerm;

  assign gameState = state;

  // Counter restarts on every state change and idles outside timed states
  assign dlyClr  = (nextState != state) || !isDelaySt(state);
  assign dlyTerm = (state == HIT) ? HIT_TERM : INTRO_TERM;

  tick_delay_counter #(.DELAY_W(DELAY_W)) uDelay (
    .clk   (clk),
    .reset (reset),
    .clr   (dlyClr),
    .tick  (tick),
    .term  (dlyTerm),
    .done  (dlyDone)
  );

  // Next-state decode; PLAY resolves charHit over levelClear over pauseBtn
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (startBtn) nextState = LVL_INTRO;
      LVL_INTRO: if (dlyDone)  nextState = PLAY;
      PLAY: begin
        if (charHit)         nextState = HIT;
        else if (levelClear) nextState = (level == LAST_LEVEL) ? WIN : LVL_CLEAR;
        else if (pauseBtn)   nextState = PAUSE;
      end
      PAUSE:     if (pauseBtn) nextState = PLAY;
      HIT:       if (dlyDone)  nextState = (lives == '0) ? LOSE : RESPAWN;
      RESPAWN:   if (dlyDone)  nextState = PLAY;
      LVL_CLEAR:               nextState = LVL_INTRO;
      WIN, LOSE: if (startBtn) nextState = IDLE;
      default:                 nextState = IDLE;
    endcase
  end

  // State, game counters and outputs registered from the next state so the
  // outputs line up with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lives       <= LIVES_INIT;
      level       <= '0;
      bubbleStart <= 1'b0;
      charStart   <= 1'b0;
      freeze      <= 1'b1;
    end else begin
      state       <= nextState;
      bubbleStart <= (nextState != state) &&
                     ((nextState == LVL_INTRO) || (nextState == RESPAWN));
      charStart   <= (nextState == PLAY);
      freeze      <= (nextState != PLAY);
      if (state == IDLE && nextState == LVL_INTRO) begin
        lives <= LIVES_INIT;
        level <= '0;
      end
      // Decrement only on the PLAY->HIT edge: one loss per PLAY visit
      if (state == PLAY && nextState == HIT && lives != '0)
        lives <= lives - 1'b1;
      if (state == PLAY && nextState == LVL_CLEAR && level != LAST_LEVEL)
        level <= level + 1'b1;
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: expected state transitions are queued
// as stimulus is applied and checked as the DUT changes state.
module tb_game_flow_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       startBtn = 1'b0, pauseBtn = 1'b0, charHit = 1'b0, levelClear = 1'b0;
  logic       bubbleStart, charStart, freeze;
  logic [3:0] lives;
  logic [2:0] level;
  logic [3:0] gameState;

  game_flow_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .startBtn(startBtn), .pauseBtn(pauseBtn),
    .charHit(charHit), .levelClear(levelClear), .bubbleStart(bubbleStart),
    .charStart(charStart), .freeze(freeze), .lives(lives), .level(level),
    .gameState(gameState)
  );

  always #5 clk = ~clk;

  typedef struct {int st; int lv; int lev; int tk; int bs;} exp_t;
  exp_t sb[$];

  int  checks = 0, errors = 0;
  bit  monOn = 0, tickEn = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input game_st_t st, input int lv, input int lev, input int tk);
    exp_t e;
    e.st = int'(st); e.lv = lv; e.lev = lev; e.tk = tk;
    e.bs = (st == LVL_INTRO || st == RESPAWN) ? 1 : 0;
    sb.push_back(e);
  endtask

  // mask: 0 start, 1 pause, 2 hit, 3 clear
  task automatic pulse(input int mask);
    @(posedge clk); #1;
    startBtn = mask[0]; pauseBtn = mask[1]; charHit = mask[2]; levelClear = mask[3];
    @(posedge clk); #1;
    startBtn = 0; pauseBtn = 0; charHit = 0; levelClear = 0;
  endtask

  task automatic waitEmpty(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin @(posedge clk); n++; end
    @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask

  task automatic waitCyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Frame tick: one strobe every third cycle
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      tick = tickEn && (ph == 2);
      ph = (ph == 2) ? 0 : ph + 1;
    end
  end

  // Monitor: every state change pops one expectation; ticks seen in the
  // previous state are tallied to check the delay lengths
  initial begin
    int   prevSt = 0, tickCnt = 0;
    bit   bsPrev = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (monOn) begin
        if (bubbleStart) chk("bs_single", int'(bsPrev), 0);
        if (int'(gameState) != prevSt) begin
          if (sb.size() == 0) chk("unexp_st", int'(gameState), prevSt);
          else begin
            e = sb.pop_front();
            chk("state", int'(gameState), e.st);
            chk("lives", int'(lives), e.lv);
            chk("level", int'(level), e.lev);
            chk("bubble", int'(bubbleStart), e.bs);
            chk("freeze", int'(freeze), (e.st != int'(PLAY)) ? 1 : 0);
            chk("charStart", int'(charStart), (e.st == int'(PLAY)) ? 1 : 0);
            if (e.tk >= 0) chk("ticks", tickCnt, e.tk);
          end
          prevSt  = int'(gameState);
          tickCnt = 0;
        end
        if (tick) tickCnt++;
      end
      bsPrev = bubbleStart;
    end
  end

  initial begin
    // Reset state
    waitCyc(3);
    @(negedge clk);
    chk("rst_state", int'(gameState), int'(IDLE));
    chk("rst_lives", int'(lives), 3);
    chk("rst_level", int'(level), 0);
    chk("rst_freeze", int'(freeze), 1);
    chk("rst_bubble", int'(bubbleStart), 0);
    chk("rst_charStart", int'(charStart), 0);
    #1 reset = 0;
    monOn = 1; tickEn = 1;

    // 1: start -> intro -> play
    push(LVL_INTRO, 3, 0, -1); push(PLAY, 3, 0, 90);
    pulse(1);
    waitEmpty("t1_drain");

    // 2: one hit, respawn, back to play
    push(HIT, 2, 0, -1); push(RESPAWN, 2, 0, 60); push(PLAY, 2, 0, 90);
    pulse(4);
    waitEmpty("t2_drain");

    // 3: two more hits -> lose, then back to idle (lives/level hold)
    push(HIT, 1, 0, -1); push(RESPAWN, 1, 0, 60); push(PLAY, 1, 0, 90);
    pulse(4);
    waitEmpty("t3a_drain");
    push(HIT, 0, 0, -1); push(LOSE, 0, 0, 60);
    pulse(4);
    waitEmpty("t3b_drain");
    push(IDLE, 0, 0, -1);
    pulse(1);
    waitEmpty("t3c_drain");

    // 4: clear levels 0..2 via LVL_CLEAR, level 3 goes straight to WIN
    push(LVL_INTRO, 3, 0, -1); push(PLAY, 3, 0, 90);
    pulse(1);
    waitEmpty("t4a_drain");
    for (int l = 0; l < 3; l++) begin
      push(LVL_CLEAR, 3, l + 1, -1); push(LVL_INTRO, 3, l + 1, -1); push(PLAY, 3, l + 1, 90);
      pulse(8);
      waitEmpty("t4b_drain");
    end
    push(WIN, 3, 3, -1);
    pulse(8);
    waitEmpty("t4c_drain");
    push(IDLE, 3, 3, -1);
    pulse(1);
    waitEmpty("t4d_drain");

    // 5: hit beats clear; pause ignores hit/clear
    push(LVL_INTRO, 3, 0, -1); push(PLAY, 3, 0, 90);
    pulse(1);
    waitEmpty("t5a_drain");
    push(HIT, 2, 0, -1); push(RESPAWN, 2, 0, 60); push(PLAY, 2, 0, 90);
    pulse(12);
    waitEmpty("t5b_drain");
    push(PAUSE, 2, 0, -1);
    pulse(2);
    waitEmpty("t5c_drain");
    pulse(12);
    waitCyc(10);
    @(negedge clk);
    chk("pause_hold", int'(gameState), int'(PAUSE));
    chk("pause_lives", int'(lives), 2);
    push(PLAY, 2, 0, -1);
    pulse(2);
    waitEmpty("t5d_drain");

    // 6: reset in the middle of HIT
    push(HIT, 1, 0, -1);
    pulse(4);
    waitEmpty("t6a_drain");
    waitCyc(30);
    push(IDLE, 3, 0, -1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    waitEmpty("t6b_drain");
    chk("t6_lives", int'(lives), 3);
    chk("t6_level", int'(level), 0);
    chk("t6_freeze", int'(freeze), 1);
    chk("t6_bubble", int'(bubbleStart), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
